rpsc_hv_sequencer: RTL and testbench

// - HV turn-on/turn-off sequencer directly downstream of the card-2 interlock logic.
//   Its act outputs drive the G1 and anode PS-active inputs of that logic.
// - Consumes the interlock status (alarm-free, G1 OK, anode ready, anode OK).
// - Brings up G1 first, then the anode, and supervises the run.
// - Any fault drops both supplies; the fault latches until an explicit clear.

---
 rtl/rpsc_hv_sequencer.sv | 134 +++++++++++++
 tb/tb_rpsc_hv_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rpsc_hv_sequencer.sv
// HV turn-on/turn-off sequencer: brings up G1, then the anode, supervises RUN, and latches faults.
// Optional fault logging (first-cause code hold plus saturating fault counter) is enabled by RPSC_SEQ_FAULT_LOG_EN.
module rpsc_hv_sequencer #(
  parameter int G1_TIMEOUT = 192,
  parameter int AN_TIMEOUT = 384,
  parameter int STOP_DELAY = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       fault_clear,
  input  logic       alarm_ok,
  input  logic       g1_ok,
  input  logic       an_ready,
  input  logic       an_ok,
  output logic       g1_ps_act,
  output logic       an_ps_act,
  output logic [2:0] state_o,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_count
);

  localparam int T_MAX = (G1_TIMEOUT > AN_TIMEOUT)
                       ? ((G1_TIMEOUT > STOP_DELAY) ? G1_TIMEOUT : STOP_DELAY)
                       : ((AN_TIMEOUT > STOP_DELAY) ? AN_TIMEOUT : STOP_DELAY);
  localparam int TW = $clog2(T_MAX) + 1;

  localparam logic [TW-1:0] G1_LAST   = TW'(G1_TIMEOUT - 1);
  localparam logic [TW-1:0] AN_LAST   = TW'(AN_TIMEOUT - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_DELAY - 1);

  localparam logic [2:0] FC_NONE  = 3'd0;
  localparam logic [2:0] FC_ALARM = 3'd1;
  localparam logic [2:0] FC_G1_TO = 3'd2;
  localparam logic [2:0] FC_AN_TO = 3'd3;
  localparam logic [2:0] FC_LOSS  = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    G1_RAMP = 3'd1,
    AN_RAMP = 3'd2,
    RUN     = 3'd3,
    STOP    = 3'd4,
    FAULT   = 3'd5
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

`ifdef RPSC_SEQ_FAULT_LOG_EN
  logic [7:0] fault_cnt;
  assign fault_count = fault_cnt;
`else
  assign fault_count = 8'd0;
`endif

  assign state_o = state;

  // Every state entry clears the timer and registers the acts decoded from the new state,
  // so the supplies follow the state on the same edge with no decode lag.
  task automatic go(input state_t nxt);
    state     <= nxt;
    timer     <= '0;
    g1_ps_act <= (nxt == G1_RAMP) || (nxt == AN_RAMP) || (nxt == RUN) || (nxt == STOP);
    an_ps_act <= (nxt == AN_RAMP) || (nxt == RUN);
    fault     <= (nxt == FAULT);
  endtask

  task automatic trip(input logic [2:0] code);
    go(FAULT);
`ifdef RPSC_SEQ_FAULT_LOG_EN
    if (fault_code == FC_NONE) fault_code <= code;
    if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
`else
    fault_code <= code;
`endif
  endtask

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      g1_ps_act  <= 1'b0;
      an_ps_act  <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
`ifdef RPSC_SEQ_FAULT_LOG_EN
      fault_cnt  <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_req && alarm_ok && !stop_req) go(G1_RAMP);
        end
        G1_RAMP: begin
          if (!alarm_ok)               trip(FC_ALARM);
          else if (stop_req)           go(STOP);
          else if (g1_ok && an_ready)  go(AN_RAMP);
          else if (timer == G1_LAST)   trip(FC_G1_TO);
          else                         timer <= timer + TW'(1);
        end
        AN_RAMP: begin
          if (!alarm_ok)               trip(FC_ALARM);
          else if (stop_req)           go(STOP);
          else if (!g1_ok)             trip(FC_LOSS);
          else if (an_ok)              go(RUN);
          else if (timer == AN_LAST)   trip(FC_AN_TO);
          else                         timer <= timer + TW'(1);
        end
        RUN: begin
          if (!alarm_ok)               trip(FC_ALARM);
          else if (stop_req)           go(STOP);
          else if (!g1_ok || !an_ok)   trip(FC_LOSS);
        end
        STOP: begin
          // Anode is already off here; G1 is held for the stop delay before returning to IDLE.
          if (!alarm_ok)               trip(FC_ALARM);
          else if (timer == STOP_LAST) go(IDLE);
          else                         timer <= timer + TW'(1);
        end
        FAULT: begin
          if (fault_clear && alarm_ok) begin
            go(IDLE);
            fault_code <= FC_NONE;
          end
        end
        default: go(IDLE);
      endcase
    end
  end

endmodule

// File: tb/tb_rpsc_hv_sequencer.sv
// Directed bench for rpsc_hv_sequencer: a table of timed input steps with expected outputs,
// followed by hand-written G1-timeout and asynchronous-reset sequences.
module tb_rpsc_hv_sequencer;

`ifdef RPSC_SEQ_FAULT_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_req = 1'b0, stop_req = 1'b0, fault_clear = 1'b0;
  logic       alarm_ok = 1'b0, g1_ok = 1'b0, an_ready = 1'b0, an_ok = 1'b0;
  logic       g1_ps_act, an_ps_act, fault;
  logic [2:0] state_o, fault_code;
  logic [7:0] fault_count;

  int checks = 0;
  int passed = 0;

  rpsc_hv_sequencer dut (
    .clk(clk), .reset(reset),
    .start_req(start_req), .stop_req(stop_req), .fault_clear(fault_clear),
    .alarm_ok(alarm_ok), .g1_ok(g1_ok), .an_ready(an_ready), .an_ok(an_ok),
    .g1_ps_act(g1_ps_act), .an_ps_act(an_ps_act), .state_o(state_o),
    .fault(fault), .fault_code(fault_code), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ins = {start, stop, clr, alarm, g1, anr, anok}; acts = {g1_act, an_act, fault}
  typedef struct {
    logic [6:0] ins;
    int         cyc;
    logic [2:0] st;
    logic [2:0] acts;
    logic [2:0] code;
    int         cnt;
  } vec_t;

  localparam int NV = 38;
  vec_t tbl [NV];

  function automatic vec_t v(input logic [6:0] ins, input int cyc, input logic [2:0] st,
                             input logic [2:0] acts, input logic [2:0] code, input int cnt);
    vec_t r;
    r.ins = ins; r.cyc = cyc; r.st = st; r.acts = acts; r.code = code; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %0d, required %0d", name, idx, act, exp);
  endtask

  task automatic chk_all(input int idx, input logic [2:0] st, input logic [2:0] acts,
                         input logic [2:0] code, input int cnt);
    chk("state", idx, {5'd0, state_o}, {5'd0, st});
    chk("g1_ps_act", idx, {7'd0, g1_ps_act}, {7'd0, acts[2]});
    chk("an_ps_act", idx, {7'd0, an_ps_act}, {7'd0, acts[1]});
    chk("fault", idx, {7'd0, fault}, {7'd0, acts[0]});
    chk("fault_code", idx, {5'd0, fault_code}, {5'd0, code});
    chk("fault_count", idx, fault_count, LOG_EN ? 8'(cnt) : 8'd0);
  endtask

  task automatic drive(input logic [6:0] ins);
    {start_req, stop_req, fault_clear, alarm_ok, g1_ok, an_ready, an_ok} = ins;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = v(7'b0001000,   2, 3'd0, 3'b000, 3'd0, 0);
    tbl[1]  = v(7'b1001010,   1, 3'd1, 3'b100, 3'd0, 0);
    tbl[2]  = v(7'b1001010, 128, 3'd1, 3'b100, 3'd0, 0);
    tbl[3]  = v(7'b1001110,   1, 3'd2, 3'b110, 3'd0, 0);
    tbl[4]  = v(7'b1001110, 259, 3'd2, 3'b110, 3'd0, 0);
    tbl[5]  = v(7'b1001111,   1, 3'd3, 3'b110, 3'd0, 0);
    tbl[6]  = v(7'b1001111,   5, 3'd3, 3'b110, 3'd0, 0);
    tbl[7]  = v(7'b1000111,   1, 3'd5, 3'b001, 3'd1, 1);
    tbl[8]  = v(7'b1001111,   3, 3'd5, 3'b001, 3'd1, 1);
    tbl[9]  = v(7'b1010111,   2, 3'd5, 3'b001, 3'd1, 1);
    tbl[10] = v(7'b0011111,   1, 3'd0, 3'b000, 3'd0, 1);
    tbl[11] = v(7'b0001111,   2, 3'd0, 3'b000, 3'd0, 1);
    tbl[12] = v(7'b1001111,   1, 3'd1, 3'b100, 3'd0, 1);
    tbl[13] = v(7'b1001111,   1, 3'd2, 3'b110, 3'd0, 1);
    tbl[14] = v(7'b1001111,   1, 3'd3, 3'b110, 3'd0, 1);
    tbl[15] = v(7'b0101111,   1, 3'd4, 3'b100, 3'd0, 1);
    tbl[16] = v(7'b0101111,  63, 3'd4, 3'b100, 3'd0, 1);
    tbl[17] = v(7'b0101111,   1, 3'd0, 3'b000, 3'd0, 1);
    tbl[18] = v(7'b0001111,   2, 3'd0, 3'b000, 3'd0, 1);
    tbl[19] = v(7'b1001111,   3, 3'd3, 3'b110, 3'd0, 1);
    tbl[20] = v(7'b1100111,   1, 3'd5, 3'b001, 3'd1, 2);
    tbl[21] = v(7'b0011111,   1, 3'd0, 3'b000, 3'd0, 2);
    tbl[22] = v(7'b1001111,   3, 3'd3, 3'b110, 3'd0, 2);
    tbl[23] = v(7'b1001110,   1, 3'd5, 3'b001, 3'd4, 3);
    tbl[24] = v(7'b0011110,   1, 3'd0, 3'b000, 3'd0, 3);
    tbl[25] = v(7'b1001110,   2, 3'd2, 3'b110, 3'd0, 3);
    tbl[26] = v(7'b1001110, 383, 3'd2, 3'b110, 3'd0, 3);
    tbl[27] = v(7'b1001110,   1, 3'd5, 3'b001, 3'd3, 4);
    tbl[28] = v(7'b0011110,   1, 3'd0, 3'b000, 3'd0, 4);
    tbl[29] = v(7'b1001110,   2, 3'd2, 3'b110, 3'd0, 4);
    tbl[30] = v(7'b1001010,   1, 3'd5, 3'b001, 3'd4, 5);
    tbl[31] = v(7'b0011010,   1, 3'd0, 3'b000, 3'd0, 5);
    tbl[32] = v(7'b1001111,   3, 3'd3, 3'b110, 3'd0, 5);
    tbl[33] = v(7'b0101111,   1, 3'd4, 3'b100, 3'd0, 5);
    tbl[34] = v(7'b0100111,   1, 3'd5, 3'b001, 3'd1, 6);
    tbl[35] = v(7'b0011111,   1, 3'd0, 3'b000, 3'd0, 6);
    tbl[36] = v(7'b1101111,   2, 3'd0, 3'b000, 3'd0, 6);
    tbl[37] = v(7'b1000111,   2, 3'd0, 3'b000, 3'd0, 6);

    tick(2);
    chk_all(-1, 3'd0, 3'b000, 3'd0, 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].ins);
      tick(tbl[i].cyc);
      chk_all(i, tbl[i].st, tbl[i].acts, tbl[i].code, tbl[i].cnt);
    end

    // G1 timeout: FAULT lands exactly 192 edges after G1_RAMP entry.
    drive(7'b1001000);
    tick(1);
    chk_all(100, 3'd1, 3'b100, 3'd0, 6);
    tick(191);
    chk_all(101, 3'd1, 3'b100, 3'd0, 6);
    tick(1);
    chk_all(102, 3'd5, 3'b001, 3'd2, 7);
    drive(7'b0011000);
    tick(1);
    chk_all(103, 3'd0, 3'b000, 3'd0, 7);

    // Asynchronous reset in the middle of AN_RAMP.
    drive(7'b1001110);
    tick(2);
    chk_all(104, 3'd2, 3'b110, 3'd0, 7);
    tick(10);
    #3 reset = 1'b1;
    #1 chk_all(105, 3'd0, 3'b000, 3'd0, 0);
    drive(7'b0001000);
    tick(1);
    reset = 1'b0;

    // Two alarm faults from G1_RAMP, each cleared.
    for (int k = 0; k < 2; k++) begin
      drive(7'b1001000);
      tick(1);
      drive(7'b1000000);
      tick(1);
      chk_all(106 + 2 * k, 3'd5, 3'b001, 3'd1, k + 1);
      drive(7'b0011000);
      tick(1);
      drive(7'b0001000);
      chk_all(107 + 2 * k, 3'd0, 3'b000, 3'd0, k + 1);
    end
    tick(2);
    chk_all(110, 3'd0, 3'b000, 3'd0, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
